// File: rtl/mbist_march_ctrl.sv
// March C- MBIST sequencer for a single-port SRAM with a 1-cycle wdata register
// and 2-cycle read latency. Element order:
//   E0 up(w0)  E1 up(r0,w1)  E2 up(r1,w0)  E3 down(r0,w1)  E4 down(r1,w0)  E5 up(r0)
// Define MBIST_DIAG_EN to add first-failure capture outputs
// (fail_addr, fail_elem, fail_data, fail_cnt).
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LAST_ADDR  = (1 << ADDR_WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MBIST_DIAG_EN
    ,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [7:0]            fail_cnt
`endif
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StBubble = 3'd1;
    localparam logic [2:0] StRun    = 3'd2;
    localparam logic [2:0] StDrain  = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);
    localparam logic [2:0]            LastElem = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  drain_q, drain_d;
    logic                  fail_q, pass_q;

    // Compare pipeline: {valid, expected bit} follows each op by two cycles
    logic v1_q, v2_q, e1_q, e2_q;

    logic [2:0] elem_nxt;
    logic       two_op, run_write, run_read, last_addr, mis;

    // Element attributes, decoded from the element number
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic elem_wval(input logic [2:0] e);
        return (e == 3'd1) || (e == 3'd3);
    endfunction

    function automatic logic elem_rexp(input logic [2:0] e);
        return (e == 3'd2) || (e == 3'd4);
    endfunction

    // Current op decode
    always_comb begin
        elem_nxt  = elem_q + 3'd1;
        two_op    = (elem_q != 3'd0) && (elem_q != LastElem);
        run_write = (elem_q == 3'd0) || (two_op && op_q);
        run_read  = (state_q == StRun) && !run_write;
        last_addr = elem_down(elem_q) ? (addr_q == '0) : (addr_q == LastAddr);
        mis       = v2_q && (mem_rdata != {DATA_WIDTH{e2_q}});
    end

    // Sequencer next state
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        drain_d = drain_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StBubble;
                    elem_d  = 3'd0;
                    op_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                end
            end
            StBubble: state_d = StRun;
            StRun: begin
                if (two_op && !op_q) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (!last_addr) begin
                        addr_d = elem_down(elem_q) ? addr_q - AddrOne : addr_q + AddrOne;
                    end else if (elem_q == LastElem) begin
                        state_d = StDrain;
                        drain_d = 1'b0;
                    end else begin
                        // wdata loaded here is visible during the bubble, ahead of
                        // the memory's one-cycle wdata register
                        state_d = StBubble;
                        elem_d  = elem_nxt;
                        addr_d  = elem_down(elem_nxt) ? LastAddr : '0;
                        wdata_d = {DATA_WIDTH{elem_wval(elem_nxt)}};
                    end
                end
            end
            StDrain: begin
                if (drain_q) state_d = StDone;
                else         drain_d = 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            elem_q  <= 3'd0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            drain_q <= drain_d;
        end
    end

    // Read-compare pipeline aligned with the memory's two-cycle read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            e1_q <= 1'b0;
            v2_q <= 1'b0;
            e2_q <= 1'b0;
        end else begin
            v1_q <= run_read;
            e1_q <= elem_rexp(elem_q);
            v2_q <= v1_q;
            e2_q <= e1_q;
        end
    end

    // Sticky fail and end-of-test pass result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q <= 1'b0;
            pass_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            fail_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            if (mis) fail_q <= 1'b1;
            // Last E5 read compares on the same edge that enters DONE
            if (state_q == StDrain && drain_q) pass_q <= !(fail_q || mis);
        end
    end

`ifdef MBIST_DIAG_EN
    logic [ADDR_WIDTH-1:0] a1_q, a2_q, faddr_q;
    logic [2:0]            el1_q, el2_q, felem_q;
    logic [DATA_WIDTH-1:0] fdata_q;
    logic [7:0]            fcnt_q;

    // First-failure capture, address/element tracked alongside the compare pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a1_q    <= '0;
            a2_q    <= '0;
            el1_q   <= 3'd0;
            el2_q   <= 3'd0;
            faddr_q <= '0;
            felem_q <= 3'd0;
            fdata_q <= '0;
            fcnt_q  <= 8'd0;
        end else begin
            a1_q  <= addr_q;
            a2_q  <= a1_q;
            el1_q <= elem_q;
            el2_q <= el1_q;
            if (state_q == StIdle && start) begin
                faddr_q <= '0;
                felem_q <= 3'd0;
                fdata_q <= '0;
                fcnt_q  <= 8'd0;
            end else if (mis) begin
                if (!fail_q) begin
                    faddr_q <= a2_q;
                    felem_q <= el2_q;
                    fdata_q <= mem_rdata;
                end
                if (fcnt_q != 8'hFF) fcnt_q <= fcnt_q + 8'd1;
            end
        end
    end

    assign fail_addr = faddr_q;
    assign fail_elem = felem_q;
    assign fail_data = fdata_q;
    assign fail_cnt  = fcnt_q;
`endif

    assign busy           = (state_q == StBubble) || (state_q == StRun) || (state_q == StDrain);
    assign done           = (state_q == StDone);
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign mem_write_read = (state_q == StRun) && run_write;
    assign mem_address    = addr_q;
    assign mem_wdata      = wdata_q;

endmodule
